// File: rtl/tick_sched.sv
// tick_sched: NCH programmable clock-enable dividers with glitch-free, boundary-aligned reprogramming
module tick_sched #(
  parameter int NCH     = 4,
  parameter int CHW     = 2,
  parameter int W       = 21,
  parameter int DEF_DIV = 50000
) (
  input  logic           clk_in,
  input  logic           rst_n,
  input  logic           cfg_valid,
  output logic           cfg_ready,
  input  logic [CHW-1:0] cfg_ch,
  input  logic [W-1:0]   cfg_div,
  output logic [NCH-1:0] tick,
  output logic [NCH-1:0] tgl,
  output logic [NCH-1:0] pend
);
  logic [(1<<CHW)-1:0] pend_ext;
  logic                xfer;
  // unimplemented channel slots read as never-pending, so they always accept
  always_comb begin
    pend_ext = '0;
    pend_ext[NCH-1:0] = pend;
  end
  assign cfg_ready = ~pend_ext[cfg_ch];
  assign xfer = cfg_valid & cfg_ready;
  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [W-1:0] cnt_q, cnt_d, div_q, div_d, nxt_q, nxt_d;
    logic         pend_q, pend_d, tick_q, tick_d, tgl_q, tgl_d;
    logic         hit, run, term;
    assign hit  = xfer && cfg_ch == CHW'(c);
    assign run  = div_q != '0;
    assign term = run && cnt_q == div_q - 1'b1;
    // running channels stage the divisor until their next terminal edge; idle ones take it now
    always_comb begin
      cnt_d  = (term || !run) ? '0 : cnt_q + 1'b1;
      div_d  = (!run && hit) ? cfg_div : (term && pend_q) ? nxt_q : div_q;
      nxt_d  = (run && hit) ? cfg_div : nxt_q;
      pend_d = (run && hit) ? 1'b1 : term ? 1'b0 : pend_q;
      tick_d = term;
      tgl_d  = tgl_q ^ term;
    end
    always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q  <= '0;
        div_q  <= W'(DEF_DIV);
        nxt_q  <= '0;
        pend_q <= 1'b0;
        tick_q <= 1'b0;
        tgl_q  <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        div_q  <= div_d;
        nxt_q  <= nxt_d;
        pend_q <= pend_d;
        tick_q <= tick_d;
        tgl_q  <= tgl_d;
      end
    end
    assign tick[c] = tick_q;
    assign tgl[c]  = tgl_q;
    assign pend[c] = pend_q;
  end
endmodule
